// File: rtl/apb_bus_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// address decode to NUM_SLV slaves, decode-error and PREADY-timeout reporting.
module apb_bus_master #(
    parameter int          NUM_SLV = 4,
    parameter logic [15:0] BASE_HI = 16'h1000,
    parameter int          TIMEOUT = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    req0_valid,
    input  logic                    req0_write,
    input  logic [31:0]             req0_addr,
    input  logic [31:0]             req0_wdata,
    output logic                    req0_done,
    output logic                    req0_err,
    output logic [31:0]             req0_rdata,
    input  logic                    req1_valid,
    input  logic                    req1_write,
    input  logic [31:0]             req1_addr,
    input  logic [31:0]             req1_wdata,
    output logic                    req1_done,
    output logic                    req1_err,
    output logic [31:0]             req1_rdata,
    output logic [31:0]             PADDR,
    output logic [31:0]             PWDATA,
    output logic                    PWRITE,
    output logic                    PENABLE,
    output logic [NUM_SLV-1:0]      PSEL,
    input  logic [32*NUM_SLV-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              grant, grant_nxt;
    logic              dec_err, dec_err_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       paddr_nxt, pwdata_nxt;
    logic              pwrite_nxt, penable_nxt;
    logic [NUM_SLV-1:0] psel_nxt;
    logic              done0_nxt, done1_nxt, err0_nxt, err1_nxt;
    logic [31:0]       rdata0_nxt, rdata1_nxt;
    logic              pick;
    logic [31:0]       pick_addr;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [IDX_W+4:0]  rd_lsb;
    logic              res_err;
    logic [31:0]       res_rdata;

    function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // On a tie the requester that did not win last time is chosen.
    assign pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign pick_addr = pick ? req1_addr : req0_addr;
    assign idx       = PADDR[12 +: IDX_W];
    assign rd_lsb    = {idx, 5'd0};

    // Next-state, latched-request and registered-output computation.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant;
        dec_err_nxt    = dec_err;
        cnt_nxt        = cnt;
        paddr_nxt      = PADDR;
        pwdata_nxt     = PWDATA;
        pwrite_nxt     = PWRITE;
        res_err        = 1'b0;
        res_rdata      = 32'd0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req0_valid || req1_valid) begin
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    dec_err_nxt    = (pick_addr[31:16] != BASE_HI);
                    state_nxt      = SETUP;
                    // Bus-facing address/data only move for decodable requests.
                    if (pick_addr[31:16] == BASE_HI) begin
                        paddr_nxt  = pick_addr;
                        pwdata_nxt = pick ? req1_wdata : req0_wdata;
                        pwrite_nxt = pick ? req1_write : req0_write;
                    end else begin
                        paddr_nxt  = PADDR;
                        pwdata_nxt = PWDATA;
                        pwrite_nxt = PWRITE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (dec_err) begin
                    state_nxt = DONE;
                    res_err   = 1'b1;
                end else begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (PREADY[idx]) begin
                    state_nxt = DONE;
                    res_rdata = PWRITE ? 32'd0 : PRDATA[rd_lsb +: 32];
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = DONE;
                    res_err   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        idx_nxt = paddr_nxt[12 +: IDX_W];
        if (((state_nxt == SETUP) || (state_nxt == ACCESS)) && !dec_err_nxt) begin
            psel_nxt = onehot(idx_nxt);
        end else begin
            psel_nxt = '0;
        end
        penable_nxt = (state_nxt == ACCESS);
        done0_nxt   = (state_nxt == DONE) && !grant_nxt;
        done1_nxt   = (state_nxt == DONE) && grant_nxt;
        err0_nxt    = done0_nxt && res_err;
        err1_nxt    = done1_nxt && res_err;
        rdata0_nxt  = done0_nxt ? res_rdata : 32'd0;
        rdata1_nxt  = done1_nxt ? res_rdata : 32'd0;
    end

    // State, request latches and all outputs; reset abandons any transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            dec_err    <= 1'b0;
            cnt        <= '0;
            PADDR      <= 32'd0;
            PWDATA     <= 32'd0;
            PWRITE     <= 1'b0;
            PENABLE    <= 1'b0;
            PSEL       <= '0;
            req0_done  <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= 32'd0;
            req1_done  <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= 32'd0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant      <= grant_nxt;
            dec_err    <= dec_err_nxt;
            cnt        <= cnt_nxt;
            PADDR      <= paddr_nxt;
            PWDATA     <= pwdata_nxt;
            PWRITE     <= pwrite_nxt;
            PENABLE    <= penable_nxt;
            PSEL       <= psel_nxt;
            req0_done  <= done0_nxt;
            req0_err   <= err0_nxt;
            req0_rdata <= rdata0_nxt;
            req1_done  <= done1_nxt;
            req1_err   <= err1_nxt;
            req1_rdata <= rdata1_nxt;
        end
    end

endmodule
